// File: rtl/sprite_rom_arbiter_if.sv
// Requester, sprite ROM, palette and response signals of sprite_rom_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's.
interface sprite_rom_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 12
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [7:0]                rom_data;
  logic [7:0]                pal_index;
  logic [11:0]               pal_rgb;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [11:0]               rsp_rgb;
  logic                      rsp_transp;

  modport slave (
    input  req, lock, addr, rom_data, pal_rgb,
    output gnt, rom_addr, pal_index, rsp_valid, rsp_rgb, rsp_transp
  );

  modport master (
    output req, lock, addr, rom_data, pal_rgb,
    input  gnt, rom_addr, pal_index, rsp_valid, rsp_rgb, rsp_transp
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sprite ROM arbiter with burst lock and a 3-stage ROM/palette pipeline.
// Define SPRITE_TRANSP_KEY_EN to key out TRANSP_INDEX as a transparent, black response.
module sprite_rom_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_W       = 12,
  parameter logic [7:0]  TRANSP_INDEX = 8'h10
) (
  input logic                  Clk,
  input logic                  Reset,
  sprite_rom_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef SPRITE_TRANSP_KEY_EN
  localparam logic KeyEn = 1'b1;
`else
  localparam logic KeyEn = 1'b0;
`endif

  typedef enum logic [0:0] {StArb, StBurst} state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_ptr, w_ptr_d;
  logic [IdxW-1:0]   r_owner, w_owner_d;

  logic              w_hold;
  logic [IdxW-1:0]   w_base;
  logic [IdxW-1:0]   w_idx;
  logic [IdxW-1:0]   w_gidx;
  logic              w_any;
  logic [NUM_REQ-1:0] w_gnt;

  logic [NUM_REQ-1:0] r_s1_tag, r_s2_tag, r_rsp_valid;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [11:0]        r_rsp_rgb, w_rgb;
  logic               r_rsp_transp, w_key;

  function automatic logic [IdxW-1:0] f_next(input logic [IdxW-1:0] i);
    f_next = (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Burst continues only while the owner keeps both req and lock asserted.
  assign w_hold = (r_state == StBurst) && bus.req[r_owner] && bus.lock[r_owner];
  assign w_base = (r_state == StBurst) ? f_next(r_owner) : r_ptr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StArb;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_owner <= w_owner_d;
    end
  end

  always_comb begin
    w_state_d = StArb;
    w_owner_d = r_owner;
    w_ptr_d   = r_ptr;
    if (w_any) begin
      if (bus.lock[w_gidx]) begin
        w_state_d = StBurst;
        w_owner_d = w_gidx;
      end else begin
        w_ptr_d = f_next(w_gidx);
      end
    end else begin
      w_ptr_d = w_base;
    end
  end

  always_comb begin
    w_gnt  = '0;
    w_gidx = '0;
    w_any  = 1'b0;
    w_idx  = w_base;
    if (!Reset) begin
      if (w_hold) begin
        w_any  = 1'b1;
        w_gidx = r_owner;
      end else begin
        for (int k = 0; k < int'(NUM_REQ); k++) begin
          if (!w_any && bus.req[w_idx]) begin
            w_any  = 1'b1;
            w_gidx = w_idx;
          end
          w_idx = f_next(w_idx);
        end
      end
      if (w_any) w_gnt[w_gidx] = 1'b1;
    end
  end

  assign w_key = KeyEn && (bus.rom_data == TRANSP_INDEX);
  assign w_rgb = w_key ? 12'h000 : bus.pal_rgb;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_s1_tag     <= '0;
      r_s2_tag     <= '0;
      r_rsp_valid  <= '0;
      r_rom_addr   <= '0;
      r_rsp_rgb    <= 12'h000;
      r_rsp_transp <= 1'b0;
    end else begin
      r_s1_tag    <= w_gnt;
      r_s2_tag    <= r_s1_tag;
      r_rsp_valid <= r_s2_tag;
      if (w_any) r_rom_addr <= bus.addr[int'(w_gidx) * int'(ADDR_W) +: ADDR_W];
      if (|r_s2_tag) begin
        r_rsp_rgb    <= w_rgb;
        r_rsp_transp <= w_key;
      end
    end
  end

  assign bus.gnt        = w_gnt;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.pal_index  = bus.rom_data;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rgb    = r_rsp_rgb;
  assign bus.rsp_transp = r_rsp_transp;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural synchronous ROM and palette.
// Transparency expectations follow SPRITE_TRANSP_KEY_EN.
module tb_sprite_rom_arbiter;

  logic Clk;
  logic Reset;
  int   n_run  = 0;
  int   n_fail = 0;

  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(12)) bus ();

  sprite_rom_arbiter #(
    .NUM_REQ      (4),
    .ADDR_W       (12),
    .TRANSP_INDEX (8'h10)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

`ifdef SPRITE_TRANSP_KEY_EN
  localparam logic [11:0] KeyRgb = 12'h000;
  localparam logic        KeyT   = 1'b1;
`else
  localparam logic [11:0] KeyRgb = 12'h01F;
  localparam logic        KeyT   = 1'b0;
`endif

  // ROM: 12'h05A holds index 8'h07, every other address holds its low byte.
  function automatic logic [7:0] rom_f(input logic [11:0] a);
    rom_f = (a == 12'h05A) ? 8'h07 : a[7:0];
  endfunction

  // Palette: index 8'h07 is 12'hE22, otherwise {lo, hi, ~lo} nibbles.
  function automatic logic [11:0] pal_f(input logic [7:0] i);
    pal_f = (i == 8'h07) ? 12'hE22 : {i[3:0], i[7:4], ~i[3:0]};
  endfunction

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) bus.rom_data <= rom_f(bus.rom_addr);
  always_comb bus.pal_rgb = pal_f(bus.pal_index);

  logic [3:0]  rr_gnt [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
  logic [3:0]  rr_vld [8] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [11:0] rr_rgb [8] = '{12'h0, 12'h0, 12'h0, 12'h00F, 12'h10E, 12'h20D, 12'h30C, 12'h00F};
  logic [11:0] rr_ra  [8] = '{12'h000, 12'h100, 12'h101, 12'h102, 12'h103, 12'h100, 12'h100,
                              12'h100};
  logic [3:0]  lk_gnt [8] = '{4'h2, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h8, 4'h1};
  logic [3:0]  rs_gnt [3] = '{4'h2, 4'h4, 4'h1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset    = 1'b1;
    bus.req  = 4'hF;
    bus.lock = 4'h0;
    bus.addr = {12'h103, 12'h102, 12'h101, 12'h100};

    // Reset state, grant forced low while Reset is high
    cyc(); #4;
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    cyc(); #4;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("rst_rsp_rgb", 32'(bus.rsp_rgb), 32'h0);
    chk("rst_rsp_transp", 32'(bus.rsp_transp), 32'h0);

    // Single requester 1 through the pipeline
    cyc(); Reset = 1'b0; bus.req = 4'b0010;
    bus.addr = {12'h103, 12'h102, 12'h05A, 12'h100}; #4;
    chk("single_gnt", 32'(bus.gnt), 32'h2);
    cyc(); bus.req = 4'h0; #4;
    chk("single_idle_gnt", 32'(bus.gnt), 32'h0);
    chk("single_rom_addr", 32'(bus.rom_addr), 32'h05A);
    cyc(); #4;
    chk("single_t2_vld", 32'(bus.rsp_valid), 32'h0);
    cyc(); #4;
    chk("single_vld", 32'(bus.rsp_valid), 32'h2);
    chk("single_rgb", 32'(bus.rsp_rgb), 32'hE22);
    chk("single_transp", 32'(bus.rsp_transp), 32'h0);
    cyc(); #4;
    chk("hold_vld", 32'(bus.rsp_valid), 32'h0);
    chk("hold_rgb", 32'(bus.rsp_rgb), 32'hE22);
    chk("hold_rom_addr", 32'(bus.rom_addr), 32'h05A);

    // Round robin from ptr=0 with all four requesting
    cyc(); Reset = 1'b1; bus.req = 4'h0;
    bus.addr = {12'h103, 12'h102, 12'h101, 12'h100};
    for (int k = 0; k < 8; k++) begin
      cyc(); Reset = 1'b0; bus.req = (k < 5) ? 4'hF : 4'h0; #4;
      chk($sformatf("rr_gnt[%0d]", k), 32'(bus.gnt), 32'(rr_gnt[k]));
      chk($sformatf("rr_vld[%0d]", k), 32'(bus.rsp_valid), 32'(rr_vld[k]));
      chk($sformatf("rr_rom_addr[%0d]", k), 32'(bus.rom_addr), 32'(rr_ra[k]));
      if (rr_vld[k] != 4'h0)
        chk($sformatf("rr_rgb[%0d]", k), 32'(bus.rsp_rgb), 32'(rr_rgb[k]));
    end

    // Burst lock on requester 2 (ptr=1 on entry)
    for (int k = 0; k < 8; k++) begin
      cyc(); bus.req = 4'hF; bus.lock = (k < 6) ? 4'b0100 : 4'b0000; #4;
      chk($sformatf("lk_gnt[%0d]", k), 32'(bus.gnt), 32'(lk_gnt[k]));
      if (k >= 3)
        chk($sformatf("lk_vld[%0d]", k), 32'(bus.rsp_valid), 32'(lk_gnt[k-3]));
    end

    // Transparent palette index
    cyc(); bus.req = 4'b0001; bus.lock = 4'h0;
    bus.addr = {12'h103, 12'h102, 12'h101, 12'h210}; #4;
    chk("key_gnt", 32'(bus.gnt), 32'h1);
    cyc(); bus.req = 4'h0;
    cyc();
    cyc(); #4;
    chk("key_vld", 32'(bus.rsp_valid), 32'h1);
    chk("key_rgb", 32'(bus.rsp_rgb), 32'(KeyRgb));
    chk("key_transp", 32'(bus.rsp_transp), 32'(KeyT));

    // Reset with three transactions in flight (ptr=1 on entry)
    bus.addr = {12'h103, 12'h102, 12'h101, 12'h100};
    for (int k = 0; k < 3; k++) begin
      cyc(); bus.req = 4'b0111; #4;
      chk($sformatf("rs_gnt[%0d]", k), 32'(bus.gnt), 32'(rs_gnt[k]));
    end
    cyc(); Reset = 1'b1; bus.req = 4'hF; #4;
    chk("rs_force_gnt", 32'(bus.gnt), 32'h0);
    chk("rs_pre_vld", 32'(bus.rsp_valid), 32'h2);
    cyc(); Reset = 1'b0; bus.req = 4'h0; #4;
    chk("rs_vld[0]", 32'(bus.rsp_valid), 32'h0);
    chk("rs_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("rs_rgb", 32'(bus.rsp_rgb), 32'h0);
    for (int k = 1; k < 3; k++) begin
      cyc(); #4;
      chk($sformatf("rs_vld[%0d]", k), 32'(bus.rsp_valid), 32'h0);
    end
    cyc(); bus.req = 4'hF; #4;
    chk("rs_ptr0_gnt", 32'(bus.gnt), 32'h1);
    cyc(); bus.req = 4'h0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
